uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between N byte-stream requesters. Round-robin arbitration;
//  a grant is held for a burst (until requester flags last, drops req, or MAX_BURST bytes).

---
 rtl/uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N byte-stream requesters. A round-robin
//   pointer picks the next owner; the owner keeps the grant for a burst that ends
//   when it flags last, drops req, or has sent MAX_BURST bytes. Bytes are paced
//   from the UART's tx_busy output so only one write happens per busy period.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   req[N]       requester i has a byte on dat[8i+7:8i]
//   dat[8N]      flattened request data, requester i at [8i+7:8i]
//   last[N]      the byte on dat of requester i ends its burst
//   ack[N]       one-cycle pulse, requester's byte taken (one-hot or 0)
//   grant[N]     one-hot current owner, 0 when idle
//   uart_wr      one-cycle write strobe to the UART
//   uart_dat     registered byte to the UART, valid while uart_wr=1
//   uart_tx_busy busy flag from the UART
//   busy         high whenever the arbiter is not idle
//   err_timeout  one-cycle pulse, UART never went busy after a write

module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [8*N-1:0] dat,
    input  logic [N-1:0]   last,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   grant,
    output logic           uart_wr,
    output logic [7:0]     uart_dat,
    input  logic           uart_tx_busy,
    output logic           busy,
    output logic           err_timeout
);

    localparam int         IW            = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] BURST_LIMIT   = 8'(MAX_BURST);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] owner, owner_n;
    logic [7:0]    burst_cnt, burst_cnt_n;
    logic [7:0]    to_cnt, to_cnt_n;
    logic          last_q, last_q_n;
    logic [N-1:0]  ack_n, grant_n;
    logic          uart_wr_n;
    logic [7:0]    uart_dat_n;
    logic          busy_n, err_n;

    logic          sel_req, sel_last;
    logic [7:0]    sel_dat;
    logic          found;
    logic [IW-1:0] pick, cand;

    // The current owner's req/last/dat, selected by its index.
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (owner == IW'(i)) begin
                sel_req  = req[i];
                sel_last = last[i];
                sel_dat  = dat[8*i +: 8];
            end
        end
    end

    // Round-robin search starting just after the last released owner, so the
    // requester that released most recently is checked last.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        burst_cnt_n = burst_cnt;
        to_cnt_n    = to_cnt;
        last_q_n    = last_q;
        grant_n     = grant;
        ack_n       = '0;
        uart_wr_n   = 1'b0;
        uart_dat_n  = uart_dat;
        err_n       = 1'b0;

        case (state)
            IDLE: begin
                if (found && !uart_tx_busy) begin
                    owner_n       = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    burst_cnt_n   = 8'd0;
                    state_n       = ISSUE;
                end
            end

            ISSUE: begin
                if (sel_req) begin
                    uart_wr_n   = 1'b1;
                    uart_dat_n  = sel_dat;
                    ack_n       = grant;
                    last_q_n    = sel_last;
                    burst_cnt_n = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;
                    to_cnt_n    = 8'd0;
                    state_n     = WAIT_BUSY;
                end else begin
                    // Requester withdrew before its byte was taken.
                    grant_n = '0;
                    ptr_n   = owner;
                    state_n = IDLE;
                end
            end

            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_n = WAIT_DONE;
                end else begin
                    to_cnt_n = (to_cnt == 8'hFF) ? to_cnt : to_cnt + 8'd1;
                    if (to_cnt_n >= TIMEOUT_LIMIT) begin
                        err_n   = 1'b1;
                        grant_n = '0;
                        ptr_n   = owner;
                        state_n = IDLE;
                    end
                end
            end

            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (!last_q && sel_req && (burst_cnt < BURST_LIMIT)) begin
                        state_n = ISSUE;
                    end else begin
                        grant_n = '0;
                        ptr_n   = owner;
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IW'(N - 1);
            owner       <= '0;
            burst_cnt   <= 8'd0;
            to_cnt      <= 8'd0;
            last_q      <= 1'b0;
            grant       <= '0;
            ack         <= '0;
            uart_wr     <= 1'b0;
            uart_dat    <= 8'h00;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            owner       <= owner_n;
            burst_cnt   <= burst_cnt_n;
            to_cnt      <= to_cnt_n;
            last_q      <= last_q_n;
            grant       <= grant_n;
            ack         <= ack_n;
            uart_wr     <= uart_wr_n;
            uart_dat    <= uart_dat_n;
            busy        <= busy_n;
            err_timeout <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Drives uart_tx_arbiter with per-requester byte queues and a simple UART
//   busy model. A transaction-level scheduler predicts the order in which bytes
//   must reach the UART; a compare process checks every write against it, plus
//   directed literal checks for reset, single byte, round-robin order, burst
//   limit, withdraw, busy timeout and reset during a burst.

module tb_uart_tx_arbiter;

    localparam int N            = 4;
    localparam int MAX_BURST    = 16;
    localparam int BUSY_TIMEOUT = 8;
    localparam int FRAME        = 6;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] dat;
    logic [N-1:0]   last;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           uart_wr;
    logic [7:0]     uart_dat;
    logic           uart_tx_busy;
    logic           busy;
    logic           err_timeout;

    logic           uart_en;
    int             frame_cnt = 0;

    item_t          reqq[N][$];
    item_t          mdlq[N][$];
    exp_t           expq[$];
    int             wrlog[$];

    int             compared   = 0;
    int             mismatched = 0;

    uart_tx_arbiter #(
        .N(N),
        .MAX_BURST(MAX_BURST),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .dat(dat),
        .last(last),
        .ack(ack),
        .grant(grant),
        .uart_wr(uart_wr),
        .uart_dat(uart_dat),
        .uart_tx_busy(uart_tx_busy),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // UART stand-in: busy for FRAME cycles after each accepted write.
    always @(posedge clk) begin
        if (uart_wr && uart_en)
            frame_cnt <= FRAME;
        else if (frame_cnt > 0)
            frame_cnt <= frame_cnt - 1;
    end
    assign uart_tx_busy = (frame_cnt != 0);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] data, input logic is_last);
        item_t it;
        it.data = data;
        it.last = is_last;
        reqq[idx].push_back(it);
        mdlq[idx].push_back(it);
    endtask

    function automatic int anyPending();
        int s = 0;
        for (int i = 0; i < N; i++) s += reqq[i].size();
        return s;
    endfunction

    // Transaction-level schedule: round-robin over requesters with pending
    // bytes, each burst ending at last, an empty queue, or MAX_BURST bytes.
    task automatic runModel(input int start_ptr);
        item_t work[N][$];
        int    p;
        p = start_ptr;
        for (int i = 0; i < N; i++) work[i] = mdlq[i];
        while (1) begin
            int g;
            int cnt;
            bit stop;
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (p + k) % N;
                if (g < 0 && work[c].size() > 0) g = c;
            end
            if (g < 0) break;
            cnt  = 0;
            stop = 1'b0;
            while (!stop) begin
                item_t it;
                exp_t  e;
                it     = work[g].pop_front();
                e.idx  = g;
                e.data = it.data;
                expq.push_back(e);
                cnt++;
                stop = it.last || (work[g].size() == 0) || (cnt >= MAX_BURST);
            end
            p = g;
        end
        for (int i = 0; i < N; i++) mdlq[i].delete();
    endtask

    task automatic assertReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            reqq[i].delete();
            mdlq[i].delete();
        end
        expq.delete();
        wrlog.delete();
        @(posedge clk);
        #2;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cyc;
        cyc = 0;
        while ((expq.size() != 0 || busy || anyPending() != 0) && cyc < 2000) begin
            @(posedge clk);
            #2;
            cyc++;
        end
        checkOutput({name, "_drain"}, 32'(expq.size()), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_grant"}, 32'(grant), 32'd0);
    endtask

    // Requester driver: pops a byte once acked, then presents the next or drops req.
    initial begin
        req  = '0;
        dat  = '0;
        last = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && reqq[i].size() > 0) void'(reqq[i].pop_front());
                if (reqq[i].size() > 0) begin
                    req[i]        = 1'b1;
                    dat[8*i +: 8] = reqq[i][0].data;
                    last[i]       = reqq[i][0].last;
                end else begin
                    req[i]        = 1'b0;
                    dat[8*i +: 8] = 8'h00;
                    last[i]       = 1'b0;
                end
            end
        end
    end

    // Compare process: every write must match the next predicted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                checkOutput("busy_vs_grant", 32'(busy), 32'(grant != '0));
                if (uart_wr) begin
                    checkOutput("wr_while_tx_busy", 32'(uart_tx_busy), 32'd0);
                    if (expq.size() == 0) begin
                        checkOutput("unexpected_write", 32'(uart_wr), 32'd0);
                    end else begin
                        exp_t         e;
                        logic [N-1:0] oh;
                        int           gi;
                        e      = expq.pop_front();
                        oh     = '0;
                        oh[e.idx] = 1'b1;
                        gi     = -1;
                        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                        wrlog.push_back(gi);
                        checkOutput("uart_dat", 32'(uart_dat), 32'(e.data));
                        checkOutput("ack_at_write", 32'(ack), 32'(oh));
                        checkOutput("grant_at_write", 32'(grant), 32'(oh));
                    end
                end else begin
                    checkOutput("ack_without_write", 32'(ack), 32'd0);
                end
                if (uart_en) checkOutput("spurious_timeout", 32'(err_timeout), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst     = 1'b1;
        uart_en = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_uart_wr", 32'(uart_wr), 32'd0);
        checkOutput("rst_uart_dat", 32'(uart_dat), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b0;

        // Single byte from requester 2
        $display("[TB] single");
        assertReset();
        releaseReset();
        applyStimulus(2, 8'h5A, 1'b1);
        runModel(N - 1);
        @(posedge clk);
        #2;
        checkOutput("single_grant", 32'(grant), 32'h4);
        @(posedge clk);
        #2;
        checkOutput("single_wr", 32'(uart_wr), 32'd1);
        checkOutput("single_dat", 32'(uart_dat), 32'h5A);
        checkOutput("single_ack", 32'(ack), 32'h4);
        waitDrain("single");

        // All four requesting at reset exit, one byte per grant
        $display("[TB] round robin");
        assertReset();
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 8'(8'h10 * (i + 1)), 1'b1);
            applyStimulus(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
        end
        runModel(N - 1);
        releaseReset();
        waitDrain("rr");
        checkOutput("rr_writes", 32'(wrlog.size()), 32'd8);
        if (wrlog.size() >= 5) begin
            checkOutput("rr_order0", 32'(wrlog[0]), 32'd0);
            checkOutput("rr_order1", 32'(wrlog[1]), 32'd1);
            checkOutput("rr_order2", 32'(wrlog[2]), 32'd2);
            checkOutput("rr_order3", 32'(wrlog[3]), 32'd3);
            checkOutput("rr_order4", 32'(wrlog[4]), 32'd0);
        end

        // Long burst from requester 1 is cut at MAX_BURST; requester 3 goes next
        $display("[TB] burst");
        assertReset();
        for (int k = 0; k < 16; k++) applyStimulus(1, 8'(8'h41 + k), 1'b0);
        applyStimulus(1, 8'h51, 1'b1);
        applyStimulus(3, 8'h77, 1'b1);
        runModel(N - 1);
        releaseReset();
        waitDrain("burst");
        checkOutput("burst_writes", 32'(wrlog.size()), 32'd18);
        if (wrlog.size() >= 18) begin
            int run;
            run = 0;
            while (run < wrlog.size() && wrlog[run] == 1) run++;
            checkOutput("burst_len", 32'(run), 32'd16);
            checkOutput("burst_next", 32'(wrlog[16]), 32'd3);
            checkOutput("burst_after", 32'(wrlog[17]), 32'd1);
        end

        // Requester 0 withdraws after one cycle
        $display("[TB] withdraw");
        assertReset();
        releaseReset();
        applyStimulus(0, 8'hEE, 1'b1);
        @(posedge clk);
        #2;
        checkOutput("withdraw_grant", 32'(grant), 32'h1);
        reqq[0].delete();
        @(posedge clk);
        #2;
        checkOutput("withdraw_release", 32'(grant), 32'd0);
        checkOutput("withdraw_busy", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("withdraw_writes", 32'(wrlog.size()), 32'd0);

        // UART never goes busy
        $display("[TB] timeout");
        assertReset();
        uart_en = 1'b0;
        releaseReset();
        applyStimulus(0, 8'hC3, 1'b1);
        runModel(N - 1);
        @(posedge clk);
        #2;
        checkOutput("timeout_grant", 32'(grant), 32'h1);
        @(posedge clk);
        #2;
        checkOutput("timeout_wr", 32'(uart_wr), 32'd1);
        for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
            @(posedge clk);
            #2;
            checkOutput($sformatf("timeout_err_c%0d", k), 32'(err_timeout),
                        (k == BUSY_TIMEOUT) ? 32'd1 : 32'd0);
        end
        checkOutput("timeout_idle_grant", 32'(grant), 32'd0);
        checkOutput("timeout_idle_busy", 32'(busy), 32'd0);
        uart_en = 1'b1;
        waitDrain("timeout");

        // Reset while waiting for the UART to finish
        $display("[TB] reset mid-burst");
        assertReset();
        releaseReset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 8'(8'h61 + k), 1'b0);
        begin
            exp_t e;
            int   cyc;
            e.idx  = 1;
            e.data = 8'h61;
            expq.push_back(e);
            cyc = 0;
            while (!uart_tx_busy && cyc < 50) begin
                @(posedge clk);
                #2;
                cyc++;
            end
        end
        checkOutput("midrst_tx_busy", 32'(uart_tx_busy), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) reqq[i].delete();
        @(posedge clk);
        #2;
        checkOutput("midrst_grant", 32'(grant), 32'd0);
        checkOutput("midrst_ack", 32'(ack), 32'd0);
        checkOutput("midrst_wr", 32'(uart_wr), 32'd0);
        checkOutput("midrst_dat", 32'(uart_dat), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        checkOutput("midrst_writes", 32'(wrlog.size()), 32'd1);
        checkOutput("midrst_drain", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
